// File: rtl/keypad_scan_fifo_pkg.sv
// Shared defaults and width helpers for the keypad scanner and its event FIFO.
// The event word is {key index, press bit}; widths derive from clog2 of the key count.
package keypad_scan_fifo_pkg;

   localparam int ROWS_DEF           = 4;
   localparam int COLS_DEF           = 4;
   localparam int SCAN_DIV_DEF       = 24000;
   localparam int DEBOUNCE_SCANS_DEF = 3;
   localparam int FIFO_DEPTH_DEF     = 4;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result++;
         rem = rem >> 1;
      end
      return result;
   endfunction

   // Never returns zero so a degenerate parameter still yields a legal vector.
   function automatic int width_of(input int value);
      return (clog2(value) > 0) ? clog2(value) : 1;
   endfunction

endpackage

// File: rtl/keypad_scan_fifo_evt_fifo.sv
// Synchronous event FIFO. The head is presented combinationally from storage while
// occupied; when empty the last popped word is held on dout.
module evt_fifo
   import keypad_scan_fifo_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = width_of(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [WIDTH-1:0] last_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? last_q : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Row-scanning keypad reader: one active-low row per slot, columns sampled mid-slot,
// per-key debounce counters, and press/release events queued in a small FIFO.
module keypad_scan_fifo
   import keypad_scan_fifo_pkg::*;
#(
   parameter int ROWS           = ROWS_DEF,
   parameter int COLS           = COLS_DEF,
   parameter int SCAN_DIV       = SCAN_DIV_DEF,
   parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF,
   parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
   input  logic                              clk_in,
   input  logic                              rst_n_in,
   input  logic [COLS-1:0]                   col_in,
   output logic [ROWS-1:0]                   row_out,
   output logic [ROWS*COLS-1:0]              key_state,
   output logic                              evt_valid,
   input  logic                              evt_ready,
   output logic [width_of(ROWS*COLS)-1:0]    evt_code,
   output logic                              evt_press,
   output logic                              ovf_flag,
   input  logic                              ovf_clr
);

   localparam int KEYS    = ROWS * COLS;
   localparam int KW      = width_of(KEYS);
   localparam int RW      = width_of(ROWS);
   localparam int CLW     = width_of(COLS);
   localparam int SW      = width_of(SCAN_DIV);
   localparam int CW      = width_of(DEBOUNCE_SCANS);
   localparam int EVAL_LO = SCAN_DIV / 2 + 1;
   localparam int EVAL_HI = SCAN_DIV / 2 + COLS;

   logic [SW-1:0]   slot_cnt;
   logic [RW-1:0]   row_idx;
   logic [RW-1:0]   next_row;
   logic            slot_wrap;
   logic [COLS-1:0] col_s1;
   logic [COLS-1:0] col_s2;
   logic [COLS-1:0] col_cap;
   logic [CW-1:0]   db_cnt [KEYS];

   logic            eval_en;
   logic [CLW-1:0]  eval_col;
   logic [KW-1:0]   key_idx;
   logic            raw;
   logic            cur_state;
   logic [CW-1:0]   cur_cnt;
   logic            differ;
   logic            qualify;
   logic            drop;

   logic            fifo_full;
   logic            fifo_empty;
   logic [KW:0]     fifo_din;
   logic [KW:0]     fifo_dout;

   // Slot timing and the key currently under evaluation.
   always_comb begin
      slot_wrap = (slot_cnt == SW'(SCAN_DIV - 1));
      next_row  = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
      eval_en   = (slot_cnt >= SW'(EVAL_LO)) && (slot_cnt <= SW'(EVAL_HI));
      eval_col  = CLW'(slot_cnt - SW'(EVAL_LO));
      key_idx   = KW'(int'(row_idx) * COLS + int'(eval_col));
      raw       = ~col_cap[eval_col];
      cur_state = key_state[key_idx];
      cur_cnt   = db_cnt[key_idx];
      differ    = eval_en && (raw != cur_state);
      qualify   = differ && (cur_cnt == CW'(DEBOUNCE_SCANS - 1));
      // The toggled state equals the raw sample, so it doubles as the press bit.
      fifo_din  = {key_idx, raw};
      drop      = qualify && fifo_full && !evt_ready;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         slot_cnt  <= '0;
         row_idx   <= '0;
         row_out   <= ~(ROWS'(1));
         col_s1    <= '1;
         col_s2    <= '1;
         col_cap   <= '1;
         key_state <= '0;
         ovf_flag  <= 1'b0;
         for (int k = 0; k < KEYS; k++) begin
            db_cnt[k] <= '0;
         end
      end else begin
         slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
         if (slot_wrap) begin
            row_idx <= next_row;
            row_out <= ~(ROWS'(1) << next_row);
         end

         col_s1 <= col_in;
         col_s2 <= col_s1;
         // Mid-slot capture leaves half a slot for the row drive to settle.
         if (slot_cnt == SW'(SCAN_DIV / 2)) begin
            col_cap <= col_s2;
         end

         if (eval_en) begin
            if (!differ) begin
               db_cnt[key_idx] <= '0;
            end else if (qualify) begin
               key_state[key_idx] <= raw;
               db_cnt[key_idx]    <= '0;
            end else begin
               db_cnt[key_idx] <= cur_cnt + 1'b1;
            end
         end

         if (drop) begin
            ovf_flag <= 1'b1;
         end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
         end
      end
   end

   evt_fifo #(
      .WIDTH (KW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .push  (qualify),
      .din   (fifo_din),
      .pop   (evt_ready),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign evt_valid = !fifo_empty;
   assign evt_code  = fifo_dout[KW:1];
   assign evt_press = fifo_dout[0];

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: a behavioural keypad drives col_in from row_out, and
// expected events are queued at stimulus time and compared as the DUT hands them out.
module tb_keypad_scan_fifo;

   localparam int ROWS     = 4;
   localparam int COLS     = 4;
   localparam int SCAN_DIV = 16;
   localparam int DB       = 3;
   localparam int DEPTH    = 4;
   localparam int FRAME    = ROWS * SCAN_DIV;
   localparam int SETTLE   = 4 * FRAME + 8;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [15:0] key_state;
   logic        evt_valid;
   logic        evt_ready;
   logic [3:0]  evt_code;
   logic        evt_press;
   logic        ovf_flag;
   logic        ovf_clr;

   logic [15:0] pressed;
   logic [15:0] prev_ks;
   logic [4:0]  exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk_in = ~clk_in;

   keypad_scan_fifo #(
      .ROWS           (ROWS),
      .COLS           (COLS),
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DB),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .col_in    (col_in),
      .row_out   (row_out),
      .key_state (key_state),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_code  (evt_code),
      .evt_press (evt_press),
      .ovf_flag  (ovf_flag),
      .ovf_clr   (ovf_clr)
   );

   // Passive keypad: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      col_in = '1;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (pressed[r*COLS+c] && !row_out[r]) begin
               col_in[c] = 1'b0;
            end
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // Returns on the negedge where row_out first shows pat (slot counter is 0 there).
   task automatic wait_row_start(input logic [3:0] pat);
      int budget;
      budget = 0;
      @(negedge clk_in);
      while (row_out == pat && budget < 200) begin
         @(negedge clk_in);
         budget++;
      end
      while (row_out != pat && budget < 200) begin
         @(negedge clk_in);
         budget++;
      end
      check_val("row_wait", 32'(row_out), 32'(pat));
   endtask

   task automatic check_reset_values();
      check_val("rst_row_out", 32'(row_out), 32'h0000_000E);
      check_val("rst_key_state", 32'(key_state), 32'h0);
      check_val("rst_evt_valid", 32'(evt_valid), 32'h0);
      check_val("rst_evt_code", 32'(evt_code), 32'h0);
      check_val("rst_evt_press", 32'(evt_press), 32'h0);
      check_val("rst_ovf_flag", 32'(ovf_flag), 32'h0);
   endtask

   // Scoreboard and continuous protocol observers.
   always @(negedge clk_in) begin
      logic [4:0] e;
      if (!rst_n_in) begin
         prev_ks = '0;
      end else begin
         check_val("row_onehot", 32'($countones(~row_out)), 32'd1);
         if (key_state != prev_ks) begin
            check_val("evt_latency", 32'(evt_valid), 32'd1);
         end
         prev_ks = key_state;
         if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
               check_val("evt_extra", 32'({evt_code, evt_press}), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check_val("evt", 32'({evt_code, evt_press}), 32'(e));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_in  = 1'b0;
      pressed   = '0;
      evt_ready = 1'b1;
      ovf_clr   = 1'b0;
      wait_cycles(3);
      check_reset_values();

      // Row rotation: slot 15 still on row 0, then row 1 takes over.
      @(negedge clk_in);
      rst_n_in = 1'b1;
      repeat (15) @(posedge clk_in);
      #1;
      check_val("row0_hold", 32'(row_out), 32'h0000_000E);
      @(posedge clk_in);
      #1;
      check_val("row1_start", 32'(row_out), 32'h0000_000D);

      // Single key row2/col1: press then release.
      wait_cycles($urandom_range(1, 40));
      pressed[9] = 1'b1;
      exp_q.push_back({4'd9, 1'b1});
      wait_cycles(2 * FRAME);
      check_val("k9_early", 32'(key_state), 32'h0);
      wait_cycles(2 * FRAME + 8);
      check_val("k9_pressed", 32'(key_state), 32'h0000_0200);
      pressed[9] = 1'b0;
      exp_q.push_back({4'd9, 1'b0});
      wait_cycles(SETTLE);
      check_val("k9_released", 32'(key_state), 32'h0);
      check_val("k9_drain", 32'(exp_q.size()), 32'd0);

      // Bounce on key 0: two samples pressed, one released, two pressed.
      pressed[0] = 1'b1;
      wait_cycles(2 * FRAME);
      pressed[0] = 1'b0;
      wait_cycles(FRAME);
      pressed[0] = 1'b1;
      wait_cycles(2 * FRAME);
      pressed[0] = 1'b0;
      wait_cycles(SETTLE);
      check_val("bounce_state", 32'(key_state), 32'h0);
      check_val("bounce_drain", 32'(exp_q.size()), 32'd0);

      // Keys 4 and 7 together: column order sets event order.
      pressed[4] = 1'b1;
      pressed[7] = 1'b1;
      exp_q.push_back({4'd4, 1'b1});
      exp_q.push_back({4'd7, 1'b1});
      wait_cycles(SETTLE);
      check_val("k47_pressed", 32'(key_state), 32'h0000_0090);
      pressed[4] = 1'b0;
      pressed[7] = 1'b0;
      exp_q.push_back({4'd4, 1'b0});
      exp_q.push_back({4'd7, 1'b0});
      wait_cycles(SETTLE);
      check_val("k47_released", 32'(key_state), 32'h0);
      check_val("k47_drain", 32'(exp_q.size()), 32'd0);

      // Overflow: four events fill the FIFO, the fifth is dropped.
      evt_ready = 1'b0;
      pressed[3:0] = 4'hF;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({4'(k), 1'b1});
      end
      wait_cycles(SETTLE);
      check_val("ovf_before", 32'(ovf_flag), 32'h0);
      pressed[15] = 1'b1;
      wait_cycles(SETTLE);
      check_val("ovf_key_state", 32'(key_state), 32'h0000_800F);
      check_val("ovf_set", 32'(ovf_flag), 32'h1);
      check_val("ovf_head", 32'({evt_valid, evt_code, evt_press}), 32'h0000_0021);
      ovf_clr = 1'b1;
      wait_cycles(1);
      ovf_clr = 1'b0;
      check_val("ovf_cleared", 32'(ovf_flag), 32'h0);
      evt_ready = 1'b1;
      wait_cycles(10);
      check_val("ovf_drain", 32'(exp_q.size()), 32'd0);
      check_val("ovf_empty", 32'(evt_valid), 32'h0);

      // Full FIFO with a pop on the exact cycle of a new push.
      evt_ready = 1'b0;
      pressed[3:0] = 4'h0;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({4'(k), 1'b0});
      end
      exp_q.push_back({4'd15, 1'b0});
      wait_cycles(SETTLE);
      check_val("full_state", 32'(key_state), 32'h0000_8000);
      wait_row_start(4'b0111);
      pressed[15] = 1'b0;
      wait_row_start(4'b0111);
      wait_row_start(4'b0111);
      repeat (12) @(posedge clk_in);
      #1;
      evt_ready = 1'b1;
      @(posedge clk_in);
      #1;
      evt_ready = 1'b0;
      check_val("full_key_state", 32'(key_state), 32'h0);
      check_val("full_ovf", 32'(ovf_flag), 32'h0);
      check_val("full_remaining", 32'(exp_q.size()), 32'd4);
      wait_cycles(5);
      evt_ready = 1'b1;
      wait_cycles(10);
      check_val("full_drain", 32'(exp_q.size()), 32'd0);
      check_val("hold_last", 32'({evt_valid, evt_code, evt_press}), 32'h0000_001E);

      // Reset with two events queued and key 5 held.
      evt_ready = 1'b0;
      pressed[9]  = 1'b1;
      pressed[10] = 1'b1;
      wait_cycles(SETTLE);
      check_val("pre_rst_queued", 32'(evt_valid), 32'h1);
      pressed[5] = 1'b1;
      wait_cycles(FRAME + $urandom_range(0, 30));
      rst_n_in = 1'b0;
      pressed[9]  = 1'b0;
      pressed[10] = 1'b0;
      wait_cycles(2);
      check_reset_values();
      @(negedge clk_in);
      rst_n_in  = 1'b1;
      evt_ready = 1'b1;
      exp_q.push_back({4'd5, 1'b1});
      repeat (150) @(posedge clk_in);
      #1;
      check_val("k5_not_yet", 32'(key_state), 32'h0);
      repeat (10) @(posedge clk_in);
      #1;
      check_val("k5_pressed", 32'(key_state), 32'h0000_0020);
      wait_cycles(5);
      check_val("k5_drain", 32'(exp_q.size()), 32'd0);
      check_val("k5_empty", 32'(evt_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_scan_fifo.md
KEYPAD_SCAN_FIFO -- requirements
Module: keypad_scan_fifo

Interface
REQ-001 Parameter ROWS, default 4: number of keypad rows driven.
REQ-002 Parameter COLS, default 4: number of keypad columns sensed.
REQ-003 Parameter SCAN_DIV, default 24000: clk_in cycles per row slot; SHALL be at least 2*COLS+2.
REQ-004 Parameter DEBOUNCE_SCANS, default 3: consecutive differing samples needed to change key state.
REQ-005 Parameter FIFO_DEPTH, default 4: event FIFO entries, power of two.
REQ-006 clk_in  in  1  the single clock for the block.
REQ-007 rst_n_in  in  1  reset, asynchronous, active-low.
REQ-008 col_in  in  COLS  keypad columns, active-low (pulled up), asynchronous to clk_in.
REQ-009 row_out  out  ROWS  row drive, active-low, exactly one bit low at all times.
REQ-010 key_state  out  ROWS*COLS  debounced state, bit row*COLS+col, 1 = pressed.
REQ-011 evt_valid  out  1  FIFO head holds an event.
REQ-012 evt_ready  in  1  consumer accepts head; pop occurs when evt_valid and evt_ready are both 1.
REQ-013 evt_code  out  clog2(ROWS*COLS)  key index row*COLS+col of the head event.
REQ-014 evt_press  out  1  head event type, 1 = press, 0 = release.
REQ-015 ovf_flag  out  1  sticky flag, set on event drop.
REQ-016 ovf_clr  in  1  synchronous clear of ovf_flag.

Function
REQ-017 Slot counter SHALL count 0..SCAN_DIV-1 and wrap; the row index SHALL advance on wrap, ROWS-1 wrapping to 0.
REQ-018 row_out SHALL drive the current row index low, registered, changing on the cycle after slot counter wrap.
REQ-019 col_in SHALL be double-flop synchronised; the synchronised value SHALL be captured at slot count SCAN_DIV/2.
REQ-020 Column c SHALL be evaluated at slot count SCAN_DIV/2+1+c, one key per cycle, ascending column order.
REQ-021 Evaluation, raw equals key_state bit: the per-key debounce counter SHALL clear.
REQ-022 Evaluation, raw differs: the counter SHALL increment; on reaching DEBOUNCE_SCANS, the key_state bit SHALL toggle, the counter SHALL clear, and one event SHALL be pushed in the same cycle.
REQ-023 The event SHALL carry code = row*COLS+col and press = new key_state bit.
REQ-024 FIFO ordering SHALL be strict first-in first-out; evt_valid/evt_code/evt_press SHALL reflect the head one cycle after a push into an empty FIFO.
REQ-025 A push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs the same cycle.
REQ-026 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-027 A rejected push SHALL drop the event, set ovf_flag, and still update key_state.
REQ-028 ovf_flag SHALL stay 1 until an ovf_clr cycle; if a set and a clear coincide, set wins.
REQ-029 When the FIFO is empty, evt_valid SHALL be 0 and evt_code/evt_press SHALL hold their last values.
REQ-030 A pop while evt_valid=0 SHALL be ignored.
REQ-031 Event latency from the last qualifying sample to evt_valid SHALL be 1 cycle, when the FIFO is empty.

Reset
REQ-032 During reset, outputs SHALL be: row_out = all ones except bit 0 low; key_state 0; evt_valid 0; evt_code 0; evt_press 0; ovf_flag 0.
REQ-033 During reset, internals SHALL be: slot counter 0, row index 0, debounce counters 0, sync flops 1, FIFO empty.
REQ-034 Reset asserted mid-scan or with the FIFO occupied SHALL discard all pending events; there SHALL be no release events for keys held at reset.

Structure
REQ-035 A shared package SHALL hold the parameter defaults and the event-field width function clog2.
REQ-036 The FIFO SHALL be the sub-module evt_fifo (sync FIFO, parameters WIDTH and DEPTH, ports push/pop/full/empty); scanning and debounce logic stays in keypad_scan_fifo.

Verification (bench: ROWS=4, COLS=4, SCAN_DIV=16, DEBOUNCE_SCANS=3, FIFO_DEPTH=4)
REQ-037 Hold key row2/col1 -> after the 3rd row-2 sample key_state[9]=1 and event (9,press=1); release -> event (9,press=0).
REQ-038 Key row0/col0 pressed for 2 scans then released -> no key_state change, no event.
REQ-039 Keys 4 and 7 (row1, col0 and col3) pressed together -> events 4 then 7 in order, key_state bits 4 and 7 set.
REQ-040 With evt_ready=0, generate 5 events -> 4 stored in order, 5th dropped, ovf_flag=1, key_state reflects all 5; one ovf_clr pulse -> ovf_flag=0.
REQ-041 FIFO full with evt_ready=1 on the cycle of a new push -> push accepted, occupancy stays 4, ovf_flag stays 0.
REQ-042 Assert rst_n_in with 2 events queued and key 5 held -> all REQ-032 values; after release with key 5 still held -> single event (5,press=1) after 3 row-1 samples.
